// File: rtl/gnss_quant_pkg.sv
// Shared 2-bit sign/magnitude code definitions for the GNSS quantizer, AGC and unpacker.
// bit1 is the sign (1 = positive); a code is large when bit1 equals bit0.
package gnss_quant_pkg;

  localparam logic [1:0] CODE_NEG_LARGE = 2'b00;
  localparam logic [1:0] CODE_NEG_SMALL = 2'b01;
  localparam logic [1:0] CODE_POS_SMALL = 2'b10;
  localparam logic [1:0] CODE_POS_LARGE = 2'b11;

  function automatic logic is_large(input logic [1:0] code);
    return code[1] ~^ code[0];
  endfunction

  function automatic logic is_pos(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/quant_window_stats.sv
// Counts large codes over back-to-back windows of 2^WIN_LOG2 fired samples and
// publishes the per-window total with a one-cycle valid pulse.
module quant_window_stats #(
  parameter int WIN_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_fire,
  input  logic                i_large,
  output logic [WIN_LOG2:0]   o_mag_count,
  output logic                o_mag_valid
);

  localparam int CW = WIN_LOG2 + 1;

  logic [WIN_LOG2-1:0] r_cnt;
  logic [CW-1:0]       r_acc;
  logic [CW-1:0]       w_acc_next;

  assign w_acc_next = r_acc + {{WIN_LOG2{1'b0}}, i_large};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      o_mag_count <= '0;
      o_mag_valid <= 1'b0;
    end else begin
      o_mag_valid <= 1'b0;
      if (i_fire) begin
        // The counter wraps to zero by itself on the completing sample.
        r_cnt <= r_cnt + {{(WIN_LOG2-1){1'b0}}, 1'b1};
        if (&r_cnt) begin
          o_mag_count <= w_acc_next;
          o_mag_valid <= 1'b1;
          r_acc       <= '0;
        end else begin
          r_acc <= w_acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/quant_unpack.sv
// Unpacks words of 2-bit sign/magnitude codes (code 0 in the MSBs) into one
// signed reconstruction level per cycle, with large-code window statistics.
module quant_unpack
  import gnss_quant_pkg::*;
#(
  parameter int CODES_PER_WORD = 4,
  parameter int OUT_W          = 4,
  parameter int LEVEL_SMALL    = 1,
  parameter int LEVEL_LARGE    = 3,
  parameter int WIN_LOG2       = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2*CODES_PER_WORD-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIN_LOG2:0]           mag_count,
  output logic                        mag_valid
);

  localparam int DW    = 2 * CODES_PER_WORD;
  localparam int IDX_W = $clog2(CODES_PER_WORD);
  localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(CODES_PER_WORD - 1);
  localparam logic signed [OUT_W-1:0] LVL_SMALL = OUT_W'(LEVEL_SMALL);
  localparam logic signed [OUT_W-1:0] LVL_LARGE = OUT_W'(LEVEL_LARGE);

  logic [DW-1:0]             r_buf;
  logic                      r_buf_valid;
  logic [IDX_W-1:0]          r_idx;

  logic [DW-1:0]             w_shift;
  logic [1:0]                w_code;
  logic                      w_last;
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic signed [OUT_W-1:0]   w_out_data;

  // Current code is always brought to the MSBs of the shifted buffer.
  assign w_shift    = r_buf << {r_idx, 1'b0};
  assign w_code     = w_shift[DW-1 -: 2];
  assign w_last     = (r_idx == IDX_LAST);
  assign w_out_fire = r_buf_valid && out_ready;
  assign in_ready   = !r_buf_valid || (out_ready && w_last);
  assign w_in_fire  = in_valid && in_ready;

  always_comb begin
    w_out_data = '0;
    if (r_buf_valid) begin
      case ({is_pos(w_code), is_large(w_code)})
        2'b11:   w_out_data = LVL_LARGE;
        2'b10:   w_out_data = LVL_SMALL;
        2'b01:   w_out_data = -LVL_LARGE;
        default: w_out_data = -LVL_SMALL;
      endcase
    end
  end

  assign out_data  = w_out_data;
  assign out_valid = r_buf_valid;

  // An input fire only happens when empty or on the last code, so it takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_idx       <= '0;
    end else if (w_in_fire) begin
      r_buf       <= in_data;
      r_buf_valid <= 1'b1;
      r_idx       <= '0;
    end else if (w_out_fire) begin
      if (w_last) begin
        r_buf_valid <= 1'b0;
        r_idx       <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  quant_window_stats #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_fire      (w_out_fire),
    .i_large     (is_large(w_code)),
    .o_mag_count (mag_count),
    .o_mag_valid (mag_valid)
  );

endmodule

// File: tb/tb_quant_unpack.sv
// Directed bench for quant_unpack with a 4-sample statistics window.
module tb_quant_unpack;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        mag_count;
  logic              mag_valid;

  int n_checks = 0;
  int n_errors = 0;

  quant_unpack #(
    .CODES_PER_WORD (4),
    .OUT_W          (4),
    .LEVEL_SMALL    (1),
    .LEVEL_LARGE    (3),
    .WIN_LOG2       (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_count (mag_count),
    .mag_valid (mag_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        d;
    logic              v;
    logic              r;
    logic              eov;
    logic signed [3:0] eod;
    logic              eir;
    logic              emv;
    logic [2:0]        emc;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic signed [3:0] lvl(input logic [1:0] code);
    case (code)
      2'b10:   return 4'sd1;
      2'b11:   return 4'sd3;
      2'b01:   return -4'sd1;
      default: return -4'sd3;
    endcase
  endfunction

  function automatic int nlarge(input logic [7:0] w);
    int n = 0;
    for (int k = 0; k < 4; k++)
      if (w[7-2*k -: 2] == 2'b11 || w[7-2*k -: 2] == 2'b00) n++;
    return n;
  endfunction

  // One cycle: drive inputs, check at the falling edge, advance past the rising edge.
  task automatic step(input logic [7:0] d, input logic v, input logic r,
                      input logic eov, input logic signed [3:0] eod, input logic eir,
                      input logic emv, input logic [2:0] emc, input string tag);
    in_data = d; in_valid = v; out_ready = r;
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, eir);
    check({tag, ".out_valid"}, out_valid, eov);
    if (eov) check({tag, ".out_data"}, out_data, eod);
    check({tag, ".mag_valid"}, mag_valid, emv);
    check({tag, ".mag_count"}, mag_count, emc);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [7:0]        words[8];
  logic [7:0]        w;
  logic              eov, emv, eir;
  logic signed [3:0] eod;
  logic [2:0]        cur_cnt;

  initial begin
    tbl[0]  = '{8'hB4, 1, 1, 0,  4'sd0, 1, 0, 3'd0};
    tbl[1]  = '{8'h00, 0, 1, 1,  4'sd1, 0, 0, 3'd0};
    tbl[2]  = '{8'h00, 0, 1, 1,  4'sd3, 0, 0, 3'd0};
    tbl[3]  = '{8'h00, 0, 1, 1, -4'sd1, 0, 0, 3'd0};
    tbl[4]  = '{8'h00, 0, 1, 1, -4'sd3, 1, 0, 3'd0};
    tbl[5]  = '{8'h00, 0, 1, 0,  4'sd0, 1, 1, 3'd2};
    tbl[6]  = '{8'h00, 0, 1, 0,  4'sd0, 1, 0, 3'd2};
    tbl[7]  = '{8'hB4, 1, 1, 0,  4'sd0, 1, 0, 3'd2};
    tbl[8]  = '{8'h00, 0, 1, 1,  4'sd1, 0, 0, 3'd2};
    tbl[9]  = '{8'h00, 0, 1, 1,  4'sd3, 0, 0, 3'd2};
    tbl[10] = '{8'hFF, 1, 0, 1, -4'sd1, 0, 0, 3'd2};
    tbl[11] = '{8'hFF, 1, 0, 1, -4'sd1, 0, 0, 3'd2};
    tbl[12] = '{8'hFF, 1, 0, 1, -4'sd1, 0, 0, 3'd2};
    tbl[13] = '{8'hFF, 1, 0, 1, -4'sd1, 0, 0, 3'd2};
    tbl[14] = '{8'hFF, 1, 0, 1, -4'sd1, 0, 0, 3'd2};
    tbl[15] = '{8'h00, 0, 1, 1, -4'sd1, 0, 0, 3'd2};
    tbl[16] = '{8'h00, 0, 1, 1, -4'sd3, 1, 0, 3'd2};
    tbl[17] = '{8'h00, 0, 1, 0,  4'sd0, 1, 1, 3'd2};

    words[0] = 8'b11_00_10_01; words[1] = 8'b00_00_00_00;
    words[2] = 8'hE4;          words[3] = 8'h1B;
    words[4] = 8'hFF;          words[5] = 8'hAA;
    words[6] = 8'h55;          words[7] = 8'h6C;

    // Reset values
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.out_data", out_data, 0);
    check("reset.mag_count", mag_count, 0);
    check("reset.mag_valid", mag_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mapping, window pulse, backpressure with ignored input during stall
    for (int i = 0; i < 18; i++)
      step(tbl[i].d, tbl[i].v, tbl[i].r, tbl[i].eov, tbl[i].eod, tbl[i].eir,
           tbl[i].emv, tbl[i].emc, $sformatf("tbl%0d", i));

    // Sustained throughput: 8 words, 32 samples, window = one word
    do_reset();
    cur_cnt = 3'd0;
    for (int c = 0; c < 34; c++) begin
      eir = (c % 4 == 0) || (c >= 32);
      eov = (c >= 1) && (c <= 32);
      eod = 4'sd0;
      if (eov) begin
        w   = words[(c-1)/4];
        eod = lvl(w[7-2*((c-1)%4) -: 2]);
      end
      emv = (c >= 5) && ((c - 1) % 4 == 0);
      if (emv) cur_cnt = 3'(nlarge(words[(c-5)/4]));
      step((c < 32) ? words[c/4] : 8'h00, c < 32, 1'b1, eov, eod, eir, emv, cur_cnt,
           $sformatf("thr%0d", c));
    end

    // Reset mid-word discards the partial word and the partial window
    step(8'hB4, 1, 1, 0, 4'sd0, 1, 0, cur_cnt, "rst.load");
    step(8'h00, 0, 1, 1, 4'sd1, 0, 0, cur_cnt, "rst.s0");
    step(8'h00, 0, 1, 1, 4'sd3, 0, 0, cur_cnt, "rst.s1");
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.out_data", out_data, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.mag_count", mag_count, 0);
    check("rst.mag_valid", mag_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(8'hFF, 1, 1, 0, 4'sd0, 1, 0, 3'd0, "post.load");
    step(8'h00, 0, 1, 1, 4'sd3, 0, 0, 3'd0, "post.s0");
    step(8'h00, 0, 1, 1, 4'sd3, 0, 0, 3'd0, "post.s1");
    step(8'h00, 0, 1, 1, 4'sd3, 0, 0, 3'd0, "post.s2");
    step(8'h00, 0, 1, 1, 4'sd3, 1, 0, 3'd0, "post.s3");
    step(8'h00, 0, 1, 0, 4'sd0, 1, 1, 3'd4, "post.win");
    step(8'h00, 0, 1, 0, 4'sd0, 1, 0, 3'd4, "post.idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
